cpu_req_gen: RTL and testbench

- Parametrised successor to the CPU-side request stimulus used in front of the AHB I-cache.
- Issues a programmable stream of instruction-fetch reads using the read_en/request_addr/hit/requested_data handshake.
- Address pattern is selectable: sequential, loop, strided or pseudo-random.
- Stalls on misses, times out on hung requests, and keeps hit/miss/stall statistics for cache benches and on-chip self-test.

---
 rtl/cpu_req_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_cpu_req_gen.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_req_gen.sv
// CPU-side instruction-fetch request generator for cache benches and self-test.
// It issues a programmable stream of reads with a selectable address pattern,
// stalls while the cache misses, aborts hung requests and keeps statistics.
module cpu_req_gen #(
  parameter int          ADDR_W    = 32,
  parameter int          DATA_W    = 32,
  parameter int          CNT_W     = 16,
  parameter int          GAP       = 0,
  parameter int          TIMEOUT   = 64,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_req,
  input  logic [CNT_W-1:0]  stride,
  input  logic [CNT_W-1:0]  loop_len,
  input  logic              hit,
  input  logic [DATA_W-1:0] requested_data,
  output logic              read_en,
  output logic [ADDR_W-1:0] request_addr,
  output logic [DATA_W-1:0] last_data,
  output logic [CNT_W-1:0]  req_count,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic              done,
  output logic              error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_GAP_WAIT,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT);
  localparam logic [31:0]      GAP_LAST    = (GAP > 0) ? 32'(GAP - 1) : 32'd0;
  localparam int               MOD_W       = (CNT_W > 16) ? CNT_W : 16;
  localparam logic [15:0]      LFSR_TAPS   = 16'hB400;

  state_t state, state_next;

  // Run configuration captured at start so input changes mid-run are harmless
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  num_q;
  logic [CNT_W-1:0]  stride_q;
  logic [CNT_W-1:0]  len_q;
  logic [ADDR_W-1:0] base_q;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  wait_cnt;
  logic [CNT_W-1:0]  off_q;
  logic [CNT_W-1:0]  req_q;
  logic [CNT_W-1:0]  hit_q;
  logic [CNT_W-1:0]  miss_q;
  logic [CNT_W-1:0]  stall_q;
  logic [31:0]       gap_cnt;
  logic [15:0]       lfsr;
  logic              err_q;

  logic              complete;
  logic              stall;
  logic              timeout_hit;
  logic              last_req;
  logic [CNT_W-1:0]  wait_inc;
  logic [CNT_W-1:0]  req_inc;
  logic [CNT_W-1:0]  len_eff;
  logic [CNT_W-1:0]  off_inc;
  logic [CNT_W-1:0]  off_next;
  logic [15:0]       lfsr_next;
  logic [MOD_W-1:0]  rand_idx;
  logic [ADDR_W-1:0] addr_next;
  logic [ADDR_W-1:0] base_aligned;

  // The two low address bits are forced to zero, so they are deliberately unused
  logic unused_base_bits;
  assign unused_base_bits = ^base_addr[1:0];

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  assign base_aligned = {base_addr[ADDR_W-1:2], 2'b00};

  // Request bookkeeping and next-address arithmetic for the active request
  always_comb begin
    complete    = (state == S_REQ) && hit;
    stall       = (state == S_REQ) && !hit;
    wait_inc    = sat_inc(wait_cnt);
    timeout_hit = (TIMEOUT != 0) && stall && (wait_inc == TIMEOUT_VAL);
    req_inc     = sat_inc(req_q);
    last_req    = (req_inc == num_q);
    len_eff     = (len_q == '0) ? CNT_W'(1) : len_q;
    off_inc     = off_q + CNT_W'(1);
    off_next    = (off_inc >= len_eff) ? '0 : off_inc;
    lfsr_next   = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
    rand_idx    = MOD_W'(lfsr_next) % MOD_W'(len_eff);
    addr_next   = addr_q;
    case (mode_q)
      2'd0:    addr_next = addr_q + ADDR_W'(4);
      2'd1:    addr_next = base_q + (ADDR_W'(off_next) << 2);
      2'd2:    addr_next = addr_q + (ADDR_W'(stride_q) << 2);
      default: addr_next = base_q + (ADDR_W'(rand_idx) << 2);
    endcase
  end

  // State register; reset abandons any request in flight
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state decision for the run sequencing
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (num_req == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        if (complete) begin
          if (last_req)      state_next = S_DONE;
          else if (GAP == 0) state_next = S_REQ;
          else               state_next = S_GAP_WAIT;
        end else if (timeout_hit) begin
          state_next = S_DONE;
        end
      end
      S_GAP_WAIT: begin
        if (gap_cnt == GAP_LAST) state_next = S_REQ;
      end
      S_DONE: begin
        if (!start) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: run setup, completion accounting, stall counting and gap timing
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q   <= 2'd0;
      num_q    <= '0;
      stride_q <= '0;
      len_q    <= '0;
      base_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wait_cnt <= '0;
      off_q    <= '0;
      req_q    <= '0;
      hit_q    <= '0;
      miss_q   <= '0;
      stall_q  <= '0;
      gap_cnt  <= '0;
      lfsr     <= LFSR_SEED;
      err_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_q   <= mode;
            num_q    <= num_req;
            stride_q <= stride;
            len_q    <= loop_len;
            base_q   <= base_aligned;
            wait_cnt <= '0;
            off_q    <= '0;
            req_q    <= '0;
            hit_q    <= '0;
            miss_q   <= '0;
            stall_q  <= '0;
            gap_cnt  <= '0;
            lfsr     <= LFSR_SEED;
            err_q    <= 1'b0;
            if (num_req != '0) addr_q <= base_aligned;
          end
        end
        S_REQ: begin
          if (complete) begin
            data_q   <= requested_data;
            req_q    <= req_inc;
            if (wait_cnt == '0) hit_q  <= sat_inc(hit_q);
            else                miss_q <= sat_inc(miss_q);
            wait_cnt <= '0;
            lfsr     <= lfsr_next;
            off_q    <= off_next;
            gap_cnt  <= '0;
            if (!last_req) addr_q <= addr_next;
          end else begin
            stall_q  <= sat_inc(stall_q);
            wait_cnt <= wait_inc;
            if (timeout_hit) err_q <= 1'b1;
          end
        end
        S_GAP_WAIT: begin
          gap_cnt <= gap_cnt + 32'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign read_en      = (state == S_REQ);
  assign done         = (state == S_DONE);
  assign error        = err_q;
  assign request_addr = addr_q;
  assign last_data    = data_q;
  assign req_count    = req_q;
  assign hit_count    = hit_q;
  assign miss_count   = miss_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_cpu_req_gen.sv
// Self-checking bench for cpu_req_gen: directed plan items plus randomised runs
// compared against an address/statistics model derived from the pattern rules.
module tb_cpu_req_gen;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst, rst_g;
  logic        start, start_g;
  logic [1:0]  mode;
  logic [31:0] base_addr;
  logic [15:0] num_req, stride, loop_len;
  logic        hit, hit_g;
  logic [31:0] requested_data, data_g;

  logic        read_en, done, error;
  logic [31:0] request_addr, last_data;
  logic [15:0] req_count, hit_count, miss_count, stall_cycles;

  logic        read_en_g, done_g, error_g;
  logic [31:0] request_addr_g, last_data_g;
  logic [15:0] req_count_g, hit_count_g, miss_count_g, stall_cycles_g;

  int checks = 0;
  int errors = 0;

  cpu_req_gen #(.GAP(0), .TIMEOUT(64), .LFSR_SEED(SEED)) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
    .num_req(num_req), .stride(stride), .loop_len(loop_len), .hit(hit),
    .requested_data(requested_data), .read_en(read_en), .request_addr(request_addr),
    .last_data(last_data), .req_count(req_count), .hit_count(hit_count),
    .miss_count(miss_count), .stall_cycles(stall_cycles), .done(done), .error(error)
  );

  cpu_req_gen #(.GAP(2), .TIMEOUT(64), .LFSR_SEED(SEED)) dut_g (
    .clk(clk), .rst(rst_g), .start(start_g), .mode(mode), .base_addr(base_addr),
    .num_req(num_req), .stride(stride), .loop_len(loop_len), .hit(hit_g),
    .requested_data(data_g), .read_en(read_en_g), .request_addr(request_addr_g),
    .last_data(last_data_g), .req_count(req_count_g), .hit_count(hit_count_g),
    .miss_count(miss_count_g), .stall_cycles(stall_cycles_g), .done(done_g),
    .error(error_g)
  );

  // Free-running clock shared by both instances
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] obs,
                              input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  // Address of the i-th request of a run, straight from the pattern rules
  function automatic logic [31:0] model_addr(input logic [1:0] m, input logic [31:0] b,
                                             input logic [15:0] s, input logic [15:0] l,
                                             input int i);
    logic [31:0] a0;
    int unsigned len;
    logic [15:0] x;
    a0  = b & ~32'h3;
    len = (l == 16'd0) ? 1 : int'(l);
    x   = SEED;
    case (m)
      2'd0: return a0 + 32'(i) * 32'd4;
      2'd1: return a0 + 32'(int'(i) % len) * 32'd4;
      2'd2: return a0 + 32'(i) * {16'h0, s} * 32'd4;
      default: begin
        if (i == 0) return a0;
        for (int k = 0; k < i; k++) x = lfsr_step(x);
        return a0 + 32'(int'(x) % len) * 32'd4;
      end
    endcase
  endfunction

  // Runs one complete transfer on the GAP=0 instance with random stall lengths
  task automatic apply_stimulus(input logic [1:0] m, input logic [31:0] b,
                                input logic [15:0] n, input logic [15:0] s,
                                input logic [15:0] l, input int max_stall);
    int stalls, exp_hits, exp_miss, exp_stall;
    logic [31:0] exp_a, exp_d;
    exp_hits = 0; exp_miss = 0; exp_stall = 0; exp_d = 32'h0;
    @(negedge clk);
    start = 1'b0; hit = 1'b0;
    @(negedge clk);
    mode = m; base_addr = b; num_req = n; stride = s; loop_len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < int'(n); i++) begin
      exp_a  = model_addr(m, b, s, l, i);
      stalls = (max_stall == 0) ? 0 : int'($urandom_range(max_stall, 0));
      for (int c = 0; c <= stalls; c++) begin
        check_output("read_en_active", read_en, 1);
        check_output("request_addr", request_addr, exp_a);
        hit = (c == stalls);
        requested_data = $urandom;
        if (c == stalls) exp_d = requested_data;
        @(negedge clk);
      end
      hit = 1'b0;
      if (stalls == 0) exp_hits++;
      else             exp_miss++;
      exp_stall += stalls;
    end
    check_output("done_end", done, 1);
    check_output("read_en_end", read_en, 0);
    check_output("error_end", error, 0);
    check_output("req_count", req_count, n);
    check_output("hit_count", hit_count, exp_hits);
    check_output("miss_count", miss_count, exp_miss);
    check_output("stall_cycles", stall_cycles, exp_stall);
    if (n != 16'd0) check_output("last_data", last_data, exp_d);
  endtask

  initial begin
    rst = 1'b1; rst_g = 1'b1; start = 1'b0; start_g = 1'b0;
    mode = 2'd0; base_addr = 32'h0; num_req = 16'h0; stride = 16'h0; loop_len = 16'h0;
    hit = 1'b0; hit_g = 1'b0; requested_data = 32'h0; data_g = 32'h0;
    repeat (2) @(negedge clk);
    rst = 1'b0; rst_g = 1'b0;

    $display("[TB] reset state");
    check_output("rst_read_en", read_en, 0);
    check_output("rst_addr", request_addr, 0);
    check_output("rst_last_data", last_data, 0);
    check_output("rst_req_count", req_count, 0);
    check_output("rst_stall", stall_cycles, 0);
    check_output("rst_done", done, 0);
    check_output("rst_error", error, 0);

    $display("[TB] sequential, all hits");
    apply_stimulus(2'd0, 32'h100, 16'd4, 16'd0, 16'd0, 0);

    $display("[TB] sequential with a 3-cycle miss");
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    mode = 2'd0; base_addr = 32'h100; num_req = 16'd2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_output("miss_hold_addr", request_addr, 32'h100);
      hit = (c == 3); requested_data = 32'h1111_0000 + 32'(c);
      @(negedge clk);
    end
    check_output("miss_second_addr", request_addr, 32'h104);
    hit = 1'b1; requested_data = 32'hCAFE_F00D;
    @(negedge clk); hit = 1'b0;
    check_output("miss_done", done, 1);
    check_output("miss_miss_count", miss_count, 1);
    check_output("miss_hit_count", hit_count, 1);
    check_output("miss_stall", stall_cycles, 3);
    check_output("miss_last_data", last_data, 32'hCAFE_F00D);

    $display("[TB] loop, strided wrap, random, empty run");
    apply_stimulus(2'd1, 32'h200, 16'd7, 16'd0, 16'd3, 0);
    apply_stimulus(2'd2, 32'hFFFF_FFF0, 16'd3, 16'd4, 16'd0, 0);
    apply_stimulus(2'd3, 32'h1000, 16'd6, 16'd0, 16'd5, 2);
    apply_stimulus(2'd1, 32'h303, 16'd4, 16'd0, 16'd0, 1);
    apply_stimulus(2'd0, 32'h500, 16'd0, 16'd0, 16'd0, 0);

    $display("[TB] timeout");
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    mode = 2'd0; base_addr = 32'h300; num_req = 16'd5; start = 1'b1; hit = 1'b0;
    @(negedge clk); start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      check_output("to_read_en", read_en, 1);
      @(negedge clk);
    end
    check_output("to_error", error, 1);
    check_output("to_done", done, 1);
    check_output("to_read_en_low", read_en, 0);
    check_output("to_req_count", req_count, 0);
    check_output("to_stall", stall_cycles, 64);
    @(negedge clk);
    check_output("to_idle_done", done, 0);
    check_output("to_idle_error", error, 1);
    apply_stimulus(2'd0, 32'h300, 16'd2, 16'd0, 16'd0, 1);

    $display("[TB] randomised runs");
    for (int r = 0; r < 12; r++) begin
      apply_stimulus(2'($urandom_range(3, 0)), $urandom, 16'($urandom_range(8, 1)),
                     16'($urandom_range(5, 0)), 16'($urandom_range(5, 0)), 3);
    end

    $display("[TB] gap instance");
    mode = 2'd0; base_addr = 32'h40; num_req = 16'd3; hit_g = 1'b1;
    data_g = 32'hA5A5_0001; start_g = 1'b1;
    @(negedge clk); start_g = 1'b0;
    for (int r = 0; r < 3; r++) begin
      check_output("gap_read_en", read_en_g, 1);
      check_output("gap_addr", request_addr_g, 32'h40 + 32'(r) * 32'd4);
      @(negedge clk);
      if (r < 2) begin
        for (int g = 0; g < 2; g++) begin
          check_output("gap_idle", read_en_g, 0);
          @(negedge clk);
        end
      end
    end
    check_output("gap_done", done_g, 1);
    check_output("gap_hit_count", hit_count_g, 3);
    check_output("gap_req_count", req_count_g, 3);

    $display("[TB] reset mid-stall");
    hit_g = 1'b0;
    @(negedge clk);
    start_g = 1'b1;
    @(negedge clk); start_g = 1'b0;
    check_output("rs_read_en", read_en_g, 1);
    repeat (2) @(negedge clk);
    check_output("rs_stall", stall_cycles_g, 2);
    rst_g = 1'b1;
    @(negedge clk); rst_g = 1'b0;
    check_output("rs_read_en_low", read_en_g, 0);
    check_output("rs_addr", request_addr_g, 0);
    check_output("rs_last_data", last_data_g, 0);
    check_output("rs_stall_clr", stall_cycles_g, 0);
    check_output("rs_hit_count", hit_count_g, 0);
    check_output("rs_done", done_g, 0);
    check_output("rs_error", error_g, 0);
    hit_g = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_output("rs_quiet", read_en_g, 0);
      check_output("rs_req_count", req_count_g, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
